sram_arb: RTL and testbench
===========================

# sram_arb

Two-port arbiter and timing controller for the board's external asynchronous 8-bit SRAM. It runs on the 90 MHz PLL output (c1) and sits between the Z80 memory bus and the video fetcher on one side and the SRAM pins on the other. It serialises CPU and video accesses, generates CE/OE/WE strobes with a programmable access length, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 19: SRAM address width.
- ACC, 3: SRAM access length in clk cycles. Legal range 2..15.

Ports:
- clk  in  1  90 MHz access clock (PLL c1).
- res  in  1  Reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_a  in  AW  CPU address.
- cpu_d  in  8  CPU write data.
- cpu_q  out  8  CPU read data.
- cpu_ack  out  1  One-cycle pulse when the CPU access completes.
- vid_req  in  1  Video read request, level.
- vid_a  in  AW  Video address.
- vid_q  out  8  Video read data.
- vid_ack  out  1  One-cycle pulse when the video access completes.
- sram_a  out  AW  SRAM address.
- sram_do  out  8  SRAM write data.
- sram_doe  out  1  Tristate enable for sram_do at the pad.
- sram_di  in  8  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.

## Operation
- States: IDLE, ACT (counter 0..ACC-1), DONE.
- Requester rule: hold req, we, a and d stable from the cycle req rises until the cycle after ack. Req may stay high for a back-to-back access. If req drops early, the access still completes and acks.
- Grant is decided in IDLE and in DONE. Eligible = req high, except the port being acked in DONE is masked for that cycle.
- Both ports eligible: grant goes to the port not granted most recently (round-robin). Last-granted resets to CPU, so video wins the first tie after reset.
- Video is read-only. For a video grant, we is treated as 0.
- On grant, latch the port id, address, we and write data. sram_a takes the latched address. Next state is ACT with count 0.
- ACT read: ce_n=0, oe_n=0, we_n=1, doe=0.
- ACT write: ce_n=0, oe_n=1, doe=1 with sram_do = latched data. we_n=1 at count 0 (address setup), we_n=0 for counts 1..ACC-1.
- ACT at count ACC-1: for a read, load sram_di into the granted port's q register. Go to DONE.
- DONE: ce_n=1, oe_n=1, we_n=1. The granted port's ack is 1.
  - After a write, doe and sram_do hold for this cycle (data hold time), then doe=0.
  - If another port is eligible, grant it and go to ACT. Otherwise go to IDLE.
- q registers hold their value until the next read for the same port.

## Timing
- All outputs are registered.
- Reset values: state IDLE, sram_a=0, sram_do=0, sram_doe=0, ce_n=oe_n=we_n=1, cpu_q=vid_q=0, cpu_ack=vid_ack=0, last-granted=CPU.
- Latency: req sampled high in IDLE at edge N. ACT covers cycles N+1..N+ACC. Ack and valid q in cycle N+ACC+1.
- Throughput: ports alternating gives one access per ACC+1 cycles. A single port streaming gives one access per ACC+2 cycles (DONE, then IDLE regrant).
- Reset asserted mid-access aborts it. Strobes go high and doe goes low asynchronously. No ack is issued, and a partially written byte is undefined.
- Reset deassertion is synchronised externally. The block only requires res to be stable for one clk.

## Test plan
- Reset: with res=1, check every output against the reset values. Release, idle 10 cycles: ce_n stays 1, no acks.
- CPU write then read, ACC=3: write 0xA5 to 0x12345, req at edge 0. we_n=0 in cycles 2–3, cpu_ack in cycle 4. Read back the same address: cpu_q=0xA5 with cpu_ack in cycle 4.
- Simultaneous vid_req and cpu_req after reset: vid_ack in cycle 4, then cpu ACT in cycles 5–7 and cpu_ack in cycle 8.
- Both requests held continuously for 40 cycles: acks alternate video/CPU every 4 cycles. No port starves, and oe_n never overlaps we_n=0.
- Reset asserted in the second ACT cycle of a write: we_n=1 and doe=0 within the same cycle, no cpu_ack. After release, a pending cpu_req is regranted from IDLE.
- ACC=2 build: single CPU read acks in cycle 3. Alternating ports give one ack every 3 cycles.

Source files
------------

// File: rtl/sram_arb.sv
// Arbiter and strobe generator for the external asynchronous 8-bit SRAM.
// It round-robins CPU and video requests and returns read data with a one-cycle ack.
module sram_arb #(
   parameter int AW  = 19,
   parameter int ACC = 3
) (
   input  logic          clk,
   input  logic          res,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_a,
   input  logic [7:0]    cpu_d,
   output logic [7:0]    cpu_q,
   output logic          cpu_ack,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_a,
   output logic [7:0]    vid_q,
   output logic          vid_ack,
   output logic [AW-1:0] sram_a,
   output logic [7:0]    sram_do,
   output logic          sram_doe,
   input  logic [7:0]    sram_di,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n
);

   typedef enum logic [1:0] {IDLE, ACT, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ACC - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       port_l, we_l, last_vid;
   logic       cpu_elig, vid_elig, grant, grant_vid, grant_we, last_act;
   logic       act_nx, wr_nx, ce_n_nx, oe_n_nx, we_n_nx, doe_nx;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // The port being acked in DONE is masked so the other port gets the next slot.
   always_comb begin
      last_act  = (state == ACT) && (cnt == LAST);
      cpu_elig  = cpu_req && !((state == DONE) && !port_l);
      vid_elig  = vid_req && !((state == DONE) && port_l);
      grant     = ((state == IDLE) || (state == DONE)) && (cpu_elig || vid_elig);
      grant_vid = vid_elig && (!cpu_elig || !last_vid);
      grant_we  = !grant_vid && cpu_we;
      state_nx  = state;
      cnt_nx    = '0;
      case (state)
         IDLE:    if (grant) state_nx = ACT;
         ACT:     if (last_act) state_nx = DONE;
                  else cnt_nx = cnt + 4'd1;
         DONE:    state_nx = grant ? ACT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Strobe values for the coming cycle, so every pin is driven from a flop.
   always_comb begin
      act_nx  = (state_nx == ACT);
      wr_nx   = grant ? grant_we : we_l;
      ce_n_nx = !act_nx;
      oe_n_nx = !(act_nx && !wr_nx);
      we_n_nx = !(act_nx && wr_nx && (cnt_nx != '0));
      doe_nx  = wr_nx && (act_nx || (state_nx == DONE));
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         sram_a    <= '0;
         sram_do   <= '0;
         sram_doe  <= 1'b0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         cpu_q     <= '0;
         vid_q     <= '0;
         cpu_ack   <= 1'b0;
         vid_ack   <= 1'b0;
         port_l    <= 1'b0;
         we_l      <= 1'b0;
         last_vid  <= 1'b0;
      end else begin
         sram_ce_n <= ce_n_nx;
         sram_oe_n <= oe_n_nx;
         sram_we_n <= we_n_nx;
         sram_doe  <= doe_nx;
         cpu_ack   <= last_act && !port_l;
         vid_ack   <= last_act && port_l;
         if (grant) begin
            port_l   <= grant_vid;
            we_l     <= grant_we;
            last_vid <= grant_vid;
            sram_a   <= grant_vid ? vid_a : cpu_a;
            if (grant_we) sram_do <= cpu_d;
         end
         if (last_act && !we_l) begin
            if (port_l) vid_q <= sram_di;
            else        cpu_q <= sram_di;
         end
      end
   end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: ACC=3 instance with a byte-accurate SRAM model and
// per-port expected-ack scoreboards, plus an ACC=2 instance for the short-access build.
module tb_sram_arb;

   localparam int AW  = 19;
   localparam int ACC = 3;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      bit         rd;
   } exp_t;

   logic          clk = 1'b0;
   logic          res;
   logic          cpu_req, cpu_we, vid_req;
   logic [AW-1:0] cpu_a, vid_a, sram_a;
   logic [7:0]    cpu_d, cpu_q, vid_q, sram_do, sram_di;
   logic          cpu_ack, vid_ack, sram_doe, sram_ce_n, sram_oe_n, sram_we_n;

   logic          cpu_req2, cpu_we2, vid_req2;
   logic [AW-1:0] cpu_a2, vid_a2, sram_a2;
   logic [7:0]    cpu_d2, cpu_q2, vid_q2, sram_do2, sram_di2;
   logic          cpu_ack2, vid_ack2, sram_doe2, sram_ce_n2, sram_oe_n2, sram_we_n2;

   exp_t       cpu_sb[$];
   exp_t       vid_sb[$];
   logic [7:0] mem [logic [AW-1:0]];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_arb #(.AW(AW), .ACC(ACC)) dut (
      .clk(clk), .res(res),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
      .cpu_q(cpu_q), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q), .vid_ack(vid_ack),
      .sram_a(sram_a), .sram_do(sram_do), .sram_doe(sram_doe), .sram_di(sram_di),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   sram_arb #(.AW(AW), .ACC(2)) u2 (
      .clk(clk), .res(res),
      .cpu_req(cpu_req2), .cpu_we(cpu_we2), .cpu_a(cpu_a2), .cpu_d(cpu_d2),
      .cpu_q(cpu_q2), .cpu_ack(cpu_ack2),
      .vid_req(vid_req2), .vid_a(vid_a2), .vid_q(vid_q2), .vid_ack(vid_ack2),
      .sram_a(sram_a2), .sram_do(sram_do2), .sram_doe(sram_doe2), .sram_di(sram_di2),
      .sram_ce_n(sram_ce_n2), .sram_oe_n(sram_oe_n2), .sram_we_n(sram_we_n2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Asynchronous SRAM: pins sampled mid-cycle, writes need the pad driver enabled.
   always @(negedge clk) begin
      if (!sram_ce_n && !sram_we_n) mem[sram_a] = sram_doe ? sram_do : 8'hxx;
      if (!sram_ce_n && !sram_oe_n) sram_di = mem.exists(sram_a) ? mem[sram_a] : 8'h00;
      else                          sram_di = 8'hEE;
      if (!sram_ce_n2 && !sram_oe_n2) sram_di2 = ~sram_a2[7:0];
      else                            sram_di2 = 8'hEE;
   end

   always @(negedge clk) begin
      exp_t e;
      if (cpu_ack) begin
         if (cpu_sb.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_ack), 0);
         else begin
            e = cpu_sb.pop_front();
            chk("cpu_ack_cycle", cyc, e.cyc);
            if (e.rd) chk("cpu_q", 32'(cpu_q), 32'(e.data));
         end
      end
      if (vid_ack) begin
         if (vid_sb.size() == 0) chk("vid_ack_unexpected", 32'(vid_ack), 0);
         else begin
            e = vid_sb.pop_front();
            chk("vid_ack_cycle", cyc, e.cyc);
            if (e.rd) chk("vid_q", 32'(vid_q), 32'(e.data));
         end
      end
      chk("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 0);
   end

   task automatic access(input bit vid, input bit we, input logic [AW-1:0] a,
                         input logic [7:0] d, input logic [7:0] q);
      int n = 0;
      @(negedge clk);
      if (vid) begin
         vid_req = 1'b1; vid_a = a;
         vid_sb.push_back('{cyc + ACC + 1, q, 1'b1});
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_d = d;
         cpu_sb.push_back('{cyc + ACC + 1, q, !we});
      end
      do begin @(negedge clk); n++; end while (!(vid ? vid_ack : cpu_ack) && n < 30);
      chk("access_done", 32'(vid ? vid_ack : cpu_ack), 1);
      cpu_req = 1'b0; vid_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int n, t, c;
      res = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_d = '0; vid_req = 0; vid_a = '0;
      cpu_req2 = 0; cpu_we2 = 0; cpu_a2 = '0; cpu_d2 = '0; vid_req2 = 0; vid_a2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_sram_a", 32'(sram_a), 0);
      chk("rst_sram_do", 32'(sram_do), 0);
      chk("rst_doe", 32'(sram_doe), 0);
      chk("rst_ce_n", 32'(sram_ce_n), 1);
      chk("rst_oe_n", 32'(sram_oe_n), 1);
      chk("rst_we_n", 32'(sram_we_n), 1);
      chk("rst_cpu_q", 32'(cpu_q), 0);
      chk("rst_vid_q", 32'(vid_q), 0);
      chk("rst_acks", 32'({cpu_ack, vid_ack}), 0);
      chk("rst2_do", 32'(sram_do2), 0);
      res = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_ce_n", 32'(sram_ce_n), 1);
         chk("idle_acks", 32'({cpu_ack, vid_ack}), 0);
      end

      // CPU write with cycle-by-cycle strobe check
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_a = 19'h12345; cpu_d = 8'hA5;
      cpu_sb.push_back('{cyc + ACC + 1, 8'h00, 1'b0});
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("wr_we_n", 32'(sram_we_n), (i == 2 || i == 3) ? 0 : 1);
         chk("wr_ce_n", 32'(sram_ce_n), (i == 4) ? 1 : 0);
         chk("wr_oe_n", 32'(sram_oe_n), 1);
         chk("wr_doe", 32'(sram_doe), 1);
         chk("wr_a", 32'(sram_a), 32'h12345);
         chk("wr_do", 32'(sram_do), 32'hA5);
      end
      cpu_req = 0;
      @(negedge clk);
      chk("wr_doe_off", 32'(sram_doe), 0);
      chk("wr_mem", 32'(mem[19'h12345]), 32'hA5);

      access(0, 0, 19'h12345, 8'h00, 8'hA5);
      access(0, 1, 19'h00001, 8'h3C, 8'h00);
      access(0, 0, 19'h00001, 8'h00, 8'h3C);
      access(1, 0, 19'h12345, 8'h00, 8'hA5);
      access(1, 0, 19'h00001, 8'h00, 8'h3C);
      chk("cpu_q_hold", 32'(cpu_q), 32'h3C);
      chk("vid_q_hold", 32'(vid_q), 32'h3C);

      // Fresh reset so last-granted is CPU, then a simultaneous request
      @(negedge clk); res = 1;
      @(negedge clk); res = 0;
      @(negedge clk);
      vid_req = 1; vid_a = 19'h12345; cpu_req = 1; cpu_we = 0; cpu_a = 19'h00001;
      vid_sb.push_back('{cyc + ACC + 1, 8'hA5, 1'b1});
      cpu_sb.push_back('{cyc + 2 * (ACC + 1), 8'h3C, 1'b1});
      n = 0;
      do begin
         @(negedge clk); n++;
         if (vid_ack) vid_req = 0;
      end while (!cpu_ack && n < 30);
      chk("tie_done", 32'(cpu_ack), 1);
      cpu_req = 0; vid_req = 0;

      // Both ports streaming: strict alternation starting with video
      @(negedge clk);
      vid_req = 1; cpu_req = 1;
      c = cyc;
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) vid_sb.push_back('{c + (k + 1) * (ACC + 1), 8'hA5, 1'b1});
         else            cpu_sb.push_back('{c + (k + 1) * (ACC + 1), 8'h3C, 1'b1});
      end
      n = 0; t = 0;
      do begin
         @(negedge clk); t++;
         if (cpu_ack || vid_ack) n++;
      end while (n < 10 && t < 100);
      chk("stream_done", n, 10);
      vid_req = 0; cpu_req = 0;

      // Reset during the second ACT cycle of a write, with the request left pending
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_a = 19'h00002; cpu_d = 8'h77;
      @(negedge clk);
      @(negedge clk);
      chk("mw_we_low", 32'(sram_we_n), 0);
      res = 1;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 1);
      chk("abort_doe", 32'(sram_doe), 0);
      chk("abort_ce_n", 32'(sram_ce_n), 1);
      @(negedge clk);
      chk("abort_no_ack", 32'(cpu_ack), 0);
      res = 0;
      cpu_sb.push_back('{cyc + ACC + 1, 8'h00, 1'b0});
      n = 0;
      do begin @(negedge clk); n++; end while (!cpu_ack && n < 30);
      chk("regrant_done", 32'(cpu_ack), 1);
      cpu_req = 0;
      access(0, 0, 19'h00002, 8'h00, 8'h77);

      // ACC=2 build: single read, then alternating ports
      @(negedge clk);
      cpu_req2 = 1; cpu_we2 = 0; cpu_a2 = 19'h00033;
      c = cyc; n = 0;
      do begin @(negedge clk); n++; end while (!cpu_ack2 && n < 30);
      chk("acc2_rd_cycle", cyc, c + 3);
      chk("acc2_rd_q", 32'(cpu_q2), 32'hCC);
      cpu_req2 = 0;
      @(negedge clk);
      cpu_req2 = 1; vid_req2 = 1; vid_a2 = 19'h000F0;
      c = cyc; n = 0; t = 0;
      do begin
         @(negedge clk); t++;
         if (cpu_ack2 || vid_ack2) begin
            n++;
            chk("acc2_alt_cycle", cyc, c + 3 * n);
            chk("acc2_alt_port", 32'(vid_ack2), n % 2);
            if (vid_ack2) chk("acc2_vid_q", 32'(vid_q2), 32'h0F);
            else          chk("acc2_cpu_q", 32'(cpu_q2), 32'hCC);
         end
      end while (n < 6 && t < 60);
      chk("acc2_alt_done", n, 6);
      cpu_req2 = 0; vid_req2 = 0;
      chk("acc2_we_n", 32'(sram_we_n2), 1);
      chk("acc2_doe", 32'(sram_doe2), 0);

      repeat (6) @(negedge clk);
      chk("cpu_sb_left", cpu_sb.size(), 0);
      chk("vid_sb_left", vid_sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
